// File: rtl/sysid_check_sequencer.sv
// Reads the two system-ID words (ID at address 0, timestamp at address 1), compares
// them against the build-time expected values, and retries a bounded number of times.
module sysid_check_sequencer #(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'h5144_634A,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic [3:0]  retry_count
);

  localparam logic [3:0] LAST_WAIT = 4'(READ_LATENCY - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CMP, DONE} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] id_reg;
  logic [31:0] ts_reg;
  logic        wait_end;
  logic        id_diff;
  logic        ts_diff;

  assign wait_end = (wait_cnt == LAST_WAIT);
  assign id_diff  = (id_reg != EXPECTED_ID);
  assign ts_diff  = (ts_reg != EXPECTED_TS);

  // Read-data capture: data registers carry no reset, only the control path does.
  always_ff @(posedge clock) begin
    if (state == RD_ID && wait_end) id_reg <= sysid_readdata;
    if (state == RD_TS && wait_end) ts_reg <= sysid_readdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= 4'd0;
      sysid_address <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      id_mismatch   <= 1'b0;
      ts_mismatch   <= 1'b0;
      retry_count   <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RD_ID;
            wait_cnt      <= 4'd0;
            sysid_address <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            id_mismatch   <= 1'b0;
            ts_mismatch   <= 1'b0;
            retry_count   <= 4'd0;
          end
        end
        RD_ID: begin
          if (wait_end) begin
            state         <= RD_TS;
            wait_cnt      <= 4'd0;
            sysid_address <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RD_TS: begin
          if (wait_end) begin
            state         <= CMP;
            wait_cnt      <= 4'd0;
            sysid_address <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        CMP: begin
          id_mismatch <= id_diff;
          ts_mismatch <= ts_diff;
          if (!id_diff && !ts_diff) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else if (retry_count == RETRY_MAX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
          end else if (wait_cnt == 4'd0) begin
            // One turnaround cycle before a retry keeps every attempt 2*READ_LATENCY+2 long.
            wait_cnt <= 4'd1;
          end else begin
            wait_cnt    <= 4'd0;
            retry_count <= retry_count + 4'd1;
            state       <= RD_ID;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check_sequencer.sv
// Directed bench: one default-latency sequencer with a combinational slave and one
// READ_LATENCY=3 sequencer fed by a registered slave.
module tb_sysid_check_sequencer;

  localparam logic [31:0] TS_GOOD = 32'h5144_634A;

  logic        clock;
  logic        reset;
  logic        start0, start3;
  logic        addr0, addr3;
  logic [31:0] readdata0, readdata3;
  logic        busy0, done0, pass0, idm0, tsm0;
  logic        busy3, done3, pass3, idm3, tsm3;
  logic [3:0]  rc0, rc3;
  logic [31:0] id_val, ts_val;
  logic [31:0] slv_s1, slv_s2;
  int          passed, total, cyc;

  sysid_check_sequencer u_dut0 (
    .clock(clock), .reset(reset), .start(start0), .sysid_address(addr0),
    .sysid_readdata(readdata0), .busy(busy0), .done(done0), .pass(pass0),
    .id_mismatch(idm0), .ts_mismatch(tsm0), .retry_count(rc0)
  );

  sysid_check_sequencer #(.READ_LATENCY(3)) u_dut3 (
    .clock(clock), .reset(reset), .start(start3), .sysid_address(addr3),
    .sysid_readdata(readdata3), .busy(busy3), .done(done3), .pass(pass3),
    .id_mismatch(idm3), .ts_mismatch(tsm3), .retry_count(rc3)
  );

  assign readdata0 = addr0 ? ts_val : id_val;

  // Two-register slave: data for a new address is valid from the third cycle on.
  always @(posedge clock) begin
    slv_s1 <= addr3 ? TS_GOOD : 32'h0;
    slv_s2 <= slv_s1;
  end
  assign readdata3 = slv_s2;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done0(inout int c);
    while (done0 !== 1'b1 && c < 100) begin
      tick();
      c++;
    end
  endtask

  task automatic wait_done3(inout int c);
    while (done3 !== 1'b1 && c < 100) begin
      tick();
      c++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    start0 = 1'b0;
    start3 = 1'b0;
    id_val = 32'h0;
    ts_val = TS_GOOD;
    tick();
    tick();
    check("rst_addr", addr0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_idm", idm0, 0);
    check("rst_tsm", tsm0, 0);
    check("rst_rc", rc0, 0);
    check("rst_done3", done3, 0);
    reset = 1'b0;
    tick();

    // Clean check at defaults: addr 0 for one cycle, 1 for one cycle, done on cycle 4.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 1;
    check("ok_addr_c1", addr0, 0);
    check("ok_busy_c1", busy0, 1);
    check("ok_done_c1", done0, 0);
    tick(); cyc++;
    check("ok_addr_c2", addr0, 1);
    tick(); cyc++;
    check("ok_addr_c3", addr0, 0);
    check("ok_busy_c3", busy0, 1);
    wait_done0(cyc);
    check("ok_latency", cyc, 4);
    check("ok_pass", pass0, 1);
    check("ok_idm", idm0, 0);
    check("ok_tsm", tsm0, 0);
    check("ok_rc", rc0, 0);
    check("ok_busy_done", busy0, 0);
    tick(); tick(); tick();
    check("ok_done_held", done0, 1);
    check("ok_pass_held", pass0, 1);

    // Timestamp always wrong: 4 attempts, done on cycle 16; a start pulse while busy is ignored.
    ts_val = 32'h5144_634B;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 1;
    repeat (4) begin tick(); cyc++; end
    start0 = 1'b1;
    tick(); cyc++;
    start0 = 1'b0;
    check("ts_busy_mid", busy0, 1);
    check("ts_done_mid", done0, 0);
    wait_done0(cyc);
    check("ts_latency", cyc, 16);
    check("ts_pass", pass0, 0);
    check("ts_tsm", tsm0, 1);
    check("ts_idm", idm0, 0);
    check("ts_rc", rc0, 3);
    ts_val = TS_GOOD;

    // ID wrong only on the first attempt: one retry, done on cycle 8.
    id_val = 32'h1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 1;
    check("id_pass_cleared", pass0, 0);
    tick(); cyc++;
    id_val = 32'h0;
    wait_done0(cyc);
    check("id_latency", cyc, 8);
    check("id_rc", rc0, 1);
    check("id_pass", pass0, 1);
    check("id_idm", idm0, 0);
    check("id_tsm", tsm0, 0);

    // Reset during RD_TS wins over a simultaneous start, which is not retained.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    check("rr_addr_rdts", addr0, 1);
    reset  = 1'b1;
    start0 = 1'b1;
    tick();
    reset  = 1'b0;
    start0 = 1'b0;
    check("rr_addr", addr0, 0);
    check("rr_busy", busy0, 0);
    check("rr_done", done0, 0);
    check("rr_pass", pass0, 0);
    check("rr_rc", rc0, 0);
    tick();
    check("rr_no_retain", busy0, 0);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 1;
    wait_done0(cyc);
    check("rr_latency", cyc, 4);
    check("rr_pass", pass0, 1);

    // Start held for two cycles from DONE starts exactly one check.
    tick();
    start0 = 1'b1;
    tick();
    cyc = 1;
    check("hold_done_drop", done0, 0);
    tick(); cyc++;
    start0 = 1'b0;
    check("hold_done_c2", done0, 0);
    wait_done0(cyc);
    check("hold_latency", cyc, 4);
    tick(); tick(); tick();
    check("hold_done_stay", done0, 1);
    check("hold_busy_stay", busy0, 0);

    // READ_LATENCY=3: each address held three cycles, done on cycle 8.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    cyc = 1;
    for (int k = 1; k <= 7; k++) begin
      check($sformatf("rl3_addr_c%0d", k), addr3, (k >= 4 && k <= 6) ? 1 : 0);
      check($sformatf("rl3_done_c%0d", k), done3, 0);
      tick();
      cyc++;
    end
    wait_done3(cyc);
    check("rl3_latency", cyc, 8);
    check("rl3_pass", pass3, 1);
    check("rl3_rc", rc3, 0);
    check("rl3_tsm", tsm3, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sysid_check_sequencer.md
SYSID_CHECK_SEQUENCER -- requirements
Module: sysid_check_sequencer

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h0000_0000: expected word at sysid address 0.
REQ-002 Parameter EXPECTED_TS, default 32'h5144_634A: expected word at sysid address 1.
REQ-003 Parameter READ_LATENCY, default 1, legal range 1..15: cycles the address is held before readdata is captured.
REQ-004 Parameter MAX_RETRIES, default 3, legal range 0..15: extra attempts after a failed compare.
REQ-005 clock  input  1: single clock; all logic is on the rising edge.
REQ-006 reset  input  1: synchronous, active-high reset.
REQ-007 start  input  1: request a check; sampled only in IDLE or DONE.
REQ-008 sysid_address  output  1: word select driven to the sysid slave.
REQ-009 sysid_readdata  input  32: read data from the sysid slave.
REQ-010 busy  output  1: high in RD_ID, RD_TS and CMP.
REQ-011 done  output  1: high in DONE; held until the next accepted start or reset.
REQ-012 pass  output  1: valid while done=1; 1 means both words matched.
REQ-013 id_mismatch  output  1: valid while done=1; captured ID differed on the final attempt.
REQ-014 ts_mismatch  output  1: valid while done=1; captured timestamp differed on the final attempt.
REQ-015 retry_count  output  4: number of retries used in the current or last check.

Function
REQ-016 The FSM SHALL have the states IDLE, RD_ID, RD_TS, CMP and DONE, encoded one-hot or binary.
REQ-017 IDLE/DONE with start=1 at an edge SHALL go to RD_ID and clear retry_count, pass, id_mismatch and ts_mismatch; done SHALL drop on that same edge.
REQ-018 start while busy=1 SHALL be ignored, with no effect on state, counters or flags.
REQ-019 In RD_ID, sysid_address SHALL be 0; a 4-bit wait counter counts READ_LATENCY cycles; sysid_readdata SHALL be captured into id_reg on the edge that ends the READ_LATENCY-th cycle, and the state SHALL then go to RD_TS with the counter cleared.
REQ-020 In RD_TS, sysid_address SHALL be 1; capture into ts_reg and the move to CMP use the same rule as REQ-019.
REQ-021 In CMP, sysid_address SHALL be 0; the block SHALL compute id_mismatch = (id_reg != EXPECTED_ID) and ts_mismatch = (ts_reg != EXPECTED_TS) as full 32-bit compares.
REQ-022 CMP with both compares equal SHALL go to DONE with pass=1.
REQ-023 CMP with any mismatch and retry_count < MAX_RETRIES SHALL increment retry_count and go to RD_ID, with mismatch flags updated but done kept at 0.
REQ-024 CMP with any mismatch and retry_count == MAX_RETRIES SHALL go to DONE with pass=0 and the final mismatch flags; retry_count SHALL saturate and never wrap.
REQ-025 Latency: the accepted start edge to the first cycle with done=1 SHALL be (2*READ_LATENCY+2)*(retries+1) cycles, e.g. 4 cycles for READ_LATENCY=1 and zero retries.
REQ-026 sysid_address SHALL be 0 in IDLE and DONE; it SHALL change only on state transitions and never inside a wait count.
REQ-027 pass, id_mismatch and ts_mismatch SHALL be registered and stable throughout DONE.

Reset
REQ-028 On reset=1 at an edge, from any state including mid-read, the block SHALL go to IDLE with sysid_address=0, busy=0, done=0, pass=0, id_mismatch=0, ts_mismatch=0, retry_count=0 and wait counter=0.
REQ-029 Reset SHALL take priority over start in the same cycle; start is not retained after reset.

Verification
REQ-030 Defaults, slave model returns 0 at addr0 and 0x5144634A at addr1, start pulsed 1 cycle -> address 0 for 1 cycle then 1 for 1 cycle, done=1 on the 4th cycle after start, pass=1, both mismatches 0, retry_count=0.
REQ-031 addr1 returns 0x5144634B always, MAX_RETRIES=3 -> 4 attempts, done at cycle 16, pass=0, ts_mismatch=1, id_mismatch=0, retry_count=3.
REQ-032 addr0 returns 0x1 on the first attempt and 0x0 afterwards -> retry_count=1, pass=1, done at cycle 8.
REQ-033 READ_LATENCY=3 with a 3-cycle registered slave model -> each address held 3 cycles, done at cycle 8, pass=1.
REQ-034 reset asserted for 1 cycle during RD_TS, then start pulsed -> all outputs 0 after reset, fresh check completes normally; start pulsed during busy is ignored (done timing unchanged).
REQ-035 done=1 then start held high for 2 cycles -> exactly one new check, done low from the accepted edge until the new result.
